// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice.
//   ALU_DEFAULT_WIDTH : default operand/result width
//   alu_op_e          : 3-bit opcode encoding
//   alu_state_e       : controller state (IDLE / BUSY)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier that handles one multiplier bit per
// clock.
//   clock_in    : clock, rising edge
//   reset_in    : asynchronous active-high reset; aborts any multiply in flight
//   start_in    : load a_in/b_in and begin (ignored while busy)
//   a_in, b_in  : operands, captured on start
//   product_out : 2*DATA_WIDTH product, valid only while done_out is high
//   done_out    : high during the cycle whose rising edge retires the last bit
//
// Timing: start seen at edge N, bits are processed at edges N+1 .. N+DATA_WIDTH.
// done_out and product_out are combinational so the parent can register the
// result at edge N+DATA_WIDTH itself, with no extra cycle of latency.
// ---------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
    output logic [2*DATA_WIDTH-1:0] product_out,
    output logic                    done_out
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                    busy_q,   busy_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [2*DATA_WIDTH-1:0] mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0] acc_q,    acc_d;
    logic [2*DATA_WIDTH-1:0] acc_sum;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        done_out = 1'b0;

        // Partial-product add for the multiplier bit currently at the LSB.
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
                done_out = 1'b1;
                busy_d   = 1'b0;
            end
        end else if (start_in) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, a_in};
            mplier_d = b_in;
        end

        product_out = acc_sum;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential ALU: single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR and an iterative
// unsigned MUL that takes DATA_WIDTH cycles.
//   clock_in            : clock, rising edge
//   reset_in            : asynchronous active-high reset
//   start_in            : request
//   operation_in        : opcode (alu_op_e encoding)
//   A_in, B_in          : operands; shifts use B_in[$clog2(DATA_WIDTH)-1:0]
//   ready_out           : high in IDLE
//   done_out            : one-cycle pulse after each result edge
//   alu_out             : registered result, held until the next result
//   zero_indicator_out  : result == 0
//   signal_bit_out      : result MSB
//   carry_out           : ADD carry / SUB borrow, else 0
//   overflow_out        : ADD/SUB signed overflow, MUL upper half nonzero
//   state_dbg_out       : controller state, for observation only
//
// Handshake: a request is accepted on a rising edge where start_in and
// ready_out are both high; opcode and operands are sampled on that edge.
// start_in while ready_out is low is dropped, never queued. Single-cycle ops
// keep the controller in IDLE so a new request can be accepted every cycle.
//
// DATA_WIDTH must be a power of two and at least 4.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [2:0]            operation_in,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    output logic                  ready_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  zero_indicator_out,
    output logic                  signal_bit_out,
    output logic                  carry_out,
    output logic                  overflow_out,
    output alu_state_e            state_dbg_out
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  sign_q, sign_d;
    logic                  carry_q, carry_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    alu_op_e               op_sel;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] comb_res;
    logic                  comb_carry;
    logic                  comb_ovf;

    logic                    mul_start;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;

    assign op_sel = alu_op_e'(operation_in);

    // Single-cycle datapath.
    always_comb begin
        sum_ext    = {1'b0, A_in} + {1'b0, B_in};
        // The extra MSB of the zero-extended difference is the borrow (A < B).
        diff_ext   = {1'b0, A_in} - {1'b0, B_in};
        shamt      = B_in[SHAMT_W-1:0];
        comb_res   = '0;
        comb_carry = 1'b0;
        comb_ovf   = 1'b0;
        case (op_sel)
            OP_ADD: begin
                comb_res   = sum_ext[DATA_WIDTH-1:0];
                comb_carry = sum_ext[DATA_WIDTH];
                // Same-sign operands producing an opposite-sign result.
                comb_ovf   = (A_in[DATA_WIDTH-1] == B_in[DATA_WIDTH-1]) &&
                             (sum_ext[DATA_WIDTH-1] != A_in[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                comb_res   = diff_ext[DATA_WIDTH-1:0];
                comb_carry = diff_ext[DATA_WIDTH];
                // Different-sign operands where the result sign differs from A.
                comb_ovf   = (A_in[DATA_WIDTH-1] != B_in[DATA_WIDTH-1]) &&
                             (diff_ext[DATA_WIDTH-1] != A_in[DATA_WIDTH-1]);
            end
            OP_AND:  comb_res = A_in & B_in;
            OP_OR:   comb_res = A_in | B_in;
            OP_XOR:  comb_res = A_in ^ B_in;
            OP_SHL:  comb_res = A_in << shamt;
            OP_SHR:  comb_res = A_in >> shamt;
            default: comb_res = '0;   // OP_MUL is handled by the multiplier
        endcase
    end

    // Controller and result/flag registers.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        sign_d    = sign_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        mul_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    if (op_sel == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        result_d = comb_res;
                        zero_d   = (comb_res == '0);
                        sign_d   = comb_res[DATA_WIDTH-1];
                        carry_d  = comb_carry;
                        ovf_d    = comb_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // start_in is deliberately not looked at here.
                if (mul_done) begin
                    result_d = mul_product[DATA_WIDTH-1:0];
                    zero_d   = (mul_product[DATA_WIDTH-1:0] == '0);
                    sign_d   = mul_product[DATA_WIDTH-1];
                    carry_d  = 1'b0;
                    ovf_d    = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .start_in    (mul_start),
        .a_in        (A_in),
        .b_in        (B_in),
        .product_out (mul_product),
        .done_out    (mul_done)
    );

    assign ready_out          = (state_q == ST_IDLE);
    assign done_out           = done_q;
    assign alu_out            = result_q;
    assign zero_indicator_out = zero_q;
    assign signal_bit_out     = sign_q;
    assign carry_out          = carry_q;
    assign overflow_out       = ovf_q;
    assign state_dbg_out      = state_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand/result width; SHALL be a power of two, >= 4.
REQ-002 clock_in  input  1  single clock; all state updates on rising edge.
REQ-003 reset_in  input  1  reset, asynchronous and active-high.
REQ-004 start_in  input  1  request; accepted only when high at a rising edge with ready_out=1.
REQ-005 operation_in  input  3  opcode, sampled on accept.
REQ-006 A_in, B_in  input  DATA_WIDTH each  operands, sampled on accept.
REQ-007 ready_out  output  1  high when in IDLE.
REQ-008 done_out  output  1  one-cycle pulse marking a new result.
REQ-009 alu_out  output  DATA_WIDTH  registered result.
REQ-010 zero_indicator_out, signal_bit_out, carry_out, overflow_out  output  1 each  registered flags.

Function
REQ-011 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR logical, 111 MUL unsigned.
REQ-012 Shift amount SHALL be B_in[$clog2(DATA_WIDTH)-1:0]; upper B bits ignored.
REQ-013 States SHALL be IDLE and BUSY; only MUL enters BUSY.
REQ-014 Non-MUL op accepted at edge N: alu_out/flags updated at edge N, done_out high for the cycle after N, state stays IDLE; back-to-back accepts every cycle allowed.
REQ-015 MUL accepted at edge N: IDLE->BUSY; iterative shift-add, one partial-product bit per cycle; result/flags updated and done_out pulsed at edge N+DATA_WIDTH; BUSY->IDLE at the same edge.
REQ-016 ready_out SHALL be low throughout BUSY; start_in during BUSY SHALL be ignored, not queued.
REQ-017 alu_out and flags SHALL hold their last value until the next result edge.
REQ-018 zero_indicator_out = (result == 0); signal_bit_out = result[DATA_WIDTH-1], all ops.
REQ-019 ADD: carry_out = unsigned carry-out; overflow_out = two's-complement signed overflow.
REQ-020 SUB: carry_out = 1 when A_in < B_in unsigned (borrow); overflow_out = signed overflow.
REQ-021 MUL: alu_out = low DATA_WIDTH bits of 2*DATA_WIDTH product; overflow_out = 1 iff upper half nonzero; carry_out = 0.
REQ-022 AND/OR/XOR/SHL/SHR: carry_out = 0, overflow_out = 0.
REQ-023 Operands and opcode SHALL be captured at accept; input changes during BUSY SHALL not affect the result.

Reset
REQ-024 While reset_in high: state IDLE, alu_out 0, all flags 0, done_out 0, multiplier accumulator/counter 0.
REQ-025 ready_out SHALL be 1 during and immediately after reset.
REQ-026 Reset asserted mid-MUL SHALL abort it: no done_out pulse, outputs cleared per REQ-024.
REQ-027 First accept SHALL be possible at the first rising edge after reset_in deasserts.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode enum, the state enum, and the default width constant.
REQ-029 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands in; 2*DATA_WIDTH product and done out; own bit counter).
REQ-030 Flag generation and single-cycle datapath SHALL remain in alu_seq.

Verification (DATA_WIDTH=16)
REQ-031 ADD 0x7FFF+0x0001 -> next cycle alu_out 0x8000, sign 1, overflow 1, carry 0, zero 0, done 1 for one cycle.
REQ-032 SUB 0x0002-0x0002 -> 0x0000, zero 1, carry 0; then SUB 0x0001-0x0002 back-to-back -> 0xFFFF, carry 1, sign 1, overflow 0.
REQ-033 MUL 0x00FF*0x0101 -> ready low 16 cycles, done at edge N+16, alu_out 0xFFFF, overflow 0; MUL 0x0100*0x0100 -> 0x0000, zero 1, overflow 1.
REQ-034 start_in pulsed with ADD operands at BUSY cycle 3 of a MUL -> ignored; only MUL result appears, single done pulse.
REQ-035 reset_in asserted at BUSY cycle 5 of a MUL -> outputs 0, ready 1, no done pulse; next ADD 0x0003+0x0001 -> 0x0004.
REQ-036 SHL 0x0001 by B=0x0013 (amount 3) -> 0x0008; SHR 0x8000 by 15 -> 0x0001, carry/overflow 0.
